// File: rtl/sm_als_ctrl.sv
// sm_als_ctrl: SPI read sequencer for an 8-bit ambient light sensor; define SM_ALS_AVG_EN to average 4 frames per result
module sm_als_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int CONV_GAP = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       auto,
  output logic       busy,
  output logic       valid,
  output logic [7:0] value,
  output logic       alsCS,
  output logic       alsSCK,
  input  logic       alsSDO
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  localparam logic [7:0] DIV_END = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_END = 8'(CONV_GAP - 1);
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  half_q, half_d;
  logic [15:0] sr_q, sr_d;
  logic        cs_q, cs_d, sck_q, sck_d, busy_q, busy_d, valid_q, valid_d;
  logic [7:0]  value_q, value_d;
  logic        div_done;
`ifdef SM_ALS_AVG_EN
  logic [9:0]  acc_q, acc_d, sum;
  logic [1:0]  frm_q, frm_d;
  assign sum = acc_q + {2'b00, sr_q[12:5]};
`endif
  assign div_done = cnt_q == DIV_END;
  assign busy     = busy_q;
  assign valid    = valid_q;
  assign value    = value_q;
  assign alsCS    = cs_q;
  assign alsSCK   = sck_q;
  // next-state: a frame is SETUP (one half-period), 32 SCK half-periods, HOLD, then the CS-high gap
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    half_d  = half_q;
    sr_d    = sr_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    value_d = value_q;
`ifdef SM_ALS_AVG_EN
    acc_d   = acc_q;
    frm_d   = frm_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d  = 8'd0;
        cs_d   = ~(start | auto);
        sck_d  = 1'b1;
        busy_d = start | auto;
        state_d = (start | auto) ? SETUP : IDLE;
      end
      SETUP: if (div_done) begin
        state_d = SHIFT;
        sck_d   = 1'b0;
        cnt_d   = 8'd0;
        half_d  = 5'd0;
      end
      SHIFT: if (div_done) begin
        cnt_d = 8'd0;
        if (half_q == 5'd31) state_d = HOLD;
        else begin
          sck_d  = ~sck_q;
          half_d = half_q + 5'd1;
          sr_d   = sck_q ? sr_q : ((sr_q << 1) | 16'(alsSDO));
        end
      end
      HOLD: if (div_done) begin
        state_d = GAP;
        cs_d    = 1'b1;
        cnt_d   = 8'd0;
`ifdef SM_ALS_AVG_EN
        valid_d = frm_q == 2'd3;
        value_d = (frm_q == 2'd3) ? sum[9:2] : value_q;
        acc_d   = (frm_q == 2'd3) ? 10'd0 : sum;
        frm_d   = frm_q + 2'd1;
`else
        valid_d = 1'b1;
        value_d = sr_q[12:5];
`endif
      end
      GAP: if (cnt_q == GAP_END) begin
        cnt_d = 8'd0;
`ifdef SM_ALS_AVG_EN
        if (auto || frm_q != 2'd0) begin
`else
        if (auto) begin
`endif
          state_d = SETUP;
          cs_d    = 1'b0;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
`ifdef SM_ALS_AVG_EN
          acc_d   = 10'd0;
          frm_d   = 2'd0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs; reset takes effect immediately, even mid-frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      half_q  <= 5'd0;
      sr_q    <= 16'd0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      value_q <= 8'h00;
`ifdef SM_ALS_AVG_EN
      acc_q   <= 10'd0;
      frm_q   <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      sr_q    <= sr_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      value_q <= value_d;
`ifdef SM_ALS_AVG_EN
      acc_q   <= acc_d;
      frm_q   <= frm_d;
`endif
    end
  end
endmodule

// File: tb/tb_sm_als_ctrl.sv
// tb_sm_als_ctrl: randomized scoreboard bench for sm_als_ctrl with a behavioural sensor stub
module tb_sm_als_ctrl;
  localparam int D = 2, G = 4, FRAME = 34 * D, PERIOD = FRAME + G;
  logic clk = 0, rst_n = 1, start = 0, auto = 0;
  logic busy, valid, alsCS, alsSCK, alsSDO;
  logic [7:0] value;
  int cyc = 0, n_cmp = 0, n_err = 0, vcnt = 0;
  logic [7:0] stub_q[$], exp_val[$];
  int exp_at[$];
  logic [15:0] word = 16'h0;
  int idx = 16;
  logic prev_sck = 1, prev_cs = 1;
  int rises = 0, last_rise = 0;
  bit aborted = 0;
  logic [7:0] ev;
  int ea;

  sm_als_ctrl #(.CLK_DIV(D), .CONV_GAP(G)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .auto(auto), .busy(busy), .valid(valid),
    .value(value), .alsCS(alsCS), .alsSCK(alsSCK), .alsSDO(alsSDO));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // sensor stub: 3 leading zeros, 8 data bits, 5 random trailing bits, MSB first
  always @(negedge alsCS) begin
    logic [7:0] d;
    d = 8'h00;
    if (stub_q.size() > 0) d = stub_q.pop_front();
    word = {3'b000, d, 5'($urandom)};
    idx = 0;
  end
  always @(posedge alsSCK) if (!alsCS && idx < 16) idx++;
  assign alsSDO = (idx < 16) ? word[15 - idx] : 1'b0;

  // monitor: scoreboard pops on valid, and SCK edges are counted per frame
  always @(negedge clk) begin
    if (valid) begin
      vcnt++;
      if (exp_val.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: value 0x%0h with nothing expected (cycle %0d)", value, cyc);
      end else begin
        ev = exp_val.pop_front();
        ea = exp_at.pop_front();
        chk("value", value, ev);
        chk("valid_cycle", cyc, ea);
      end
    end
    if (prev_cs && !alsCS) rises = 0;
    if (!alsCS && !prev_sck && alsSCK) begin
      rises++;
      if (rises > 1) chk("sck_spacing", cyc - last_rise, 2 * D);
      last_rise = cyc;
    end
    if (!prev_cs && alsCS) begin
      if (aborted) aborted = 0;
      else chk("sck_rises", rises, 16);
    end
    prev_sck = alsSCK;
    prev_cs = alsCS;
  end

  task automatic wait_until(int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle(int exp_t);
    int lim;
    lim = cyc + 2000;
    while (busy && cyc < lim) @(negedge clk);
    chk("busy_drop_cycle", cyc, exp_t);
  endtask

  task automatic begin_frame(bit s, bit a, output int n0);
    start = s;
    auto = a;
    n0 = cyc + 1;
    @(negedge clk);
    start = 0;
    chk("cs_low_at_start", alsCS, 0);
    chk("busy_at_start", busy, 1);
  endtask

  task automatic run_single(logic [7:0] d, bit s, bit a, int again);
    int n0, v0;
    v0 = vcnt;
    stub_q.push_back(d);
    begin_frame(s, a, n0);
    auto = 0;
    exp_val.push_back(d);
    exp_at.push_back(n0 + FRAME);
    if (again > 0) begin
      wait_until(n0 + again - 1);
      start = 1;
      @(negedge clk);
      start = 0;
    end
    wait_idle(n0 + PERIOD);
    chk("one_valid", vcnt - v0, 1);
    chk("sb_drained", exp_val.size(), 0);
  endtask

  task automatic run_avg(logic [7:0] d0, logic [7:0] d1, logic [7:0] d2, logic [7:0] d3);
    int n0, v0, sum;
    v0 = vcnt;
    stub_q.push_back(d0); stub_q.push_back(d1); stub_q.push_back(d2); stub_q.push_back(d3);
    sum = int'(d0) + int'(d1) + int'(d2) + int'(d3);
    begin_frame(1, 0, n0);
    exp_val.push_back(8'(sum / 4));
    exp_at.push_back(n0 + 3 * PERIOD + FRAME);
    wait_idle(n0 + 4 * PERIOD);
    chk("one_avg_valid", vcnt - v0, 1);
  endtask

  initial begin
    int n0, v0, m;
    logic [7:0] a, b;
    #1 rst_n = 0;
    repeat (4) @(negedge clk);
    chk("rst_cs", alsCS, 1);
    chk("rst_sck", alsSCK, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_value", value, 0);
    rst_n = 1;
    @(negedge clk);
`ifdef SM_ALS_AVG_EN
    run_avg(8'h10, 8'h20, 8'h30, 8'h41);
    repeat (3) @(negedge clk);
    run_avg(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
`else
    run_single(8'h5A, 1, 0, 20);
    a = 8'($urandom);
    b = 8'($urandom);
    v0 = vcnt;
    stub_q.push_back(a);
    stub_q.push_back(b);
    begin_frame(0, 1, n0);
    exp_val.push_back(a); exp_at.push_back(n0 + FRAME);
    exp_val.push_back(b); exp_at.push_back(n0 + PERIOD + FRAME);
    wait_until(n0 + FRAME + G - 1);
    chk("gap_cs_high", alsCS, 1);
    wait_until(n0 + FRAME + G);
    chk("auto_cs_relow", alsCS, 0);
    chk("auto_busy_held", busy, 1);
    wait_until(n0 + 100);
    auto = 0;
    wait_idle(n0 + 2 * PERIOD);
    chk("auto_two_valids", vcnt - v0, 2);
    for (int i = 0; i < 5; i++) begin
      m = $urandom_range(0, 2);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_single(8'($urandom), m != 1, m != 0, 0);
    end
    run_single(8'hC3, 1, 0, 0);
    stub_q.push_back(8'($urandom));
    begin_frame(1, 0, n0);
    wait_until(n0 + 30);
    aborted = 1;
    #2 rst_n = 0;
    #1;
    chk("async_rst_cs", alsCS, 1);
    chk("async_rst_sck", alsSCK, 1);
    chk("async_rst_value", value, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_no_edge", cyc, n0 + 30);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run_single(8'($urandom), 1, 0, 0);
`endif
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
